// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, committed exception codes and
// Status/Cause field positions used by the exception controller and its timer.
package cp0_exc_ctrl_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [31:0] EXC_NONE = 32'h0;
    localparam logic [31:0] EXC_INT  = 32'h1;
    localparam logic [31:0] EXC_ADEL = 32'h4;
    localparam logic [31:0] EXC_ADES = 32'h5;
    localparam logic [31:0] EXC_SYS  = 32'h8;
    localparam logic [31:0] EXC_BP   = 32'h9;
    localparam logic [31:0] EXC_RI   = 32'hA;
    localparam logic [31:0] EXC_OV   = 32'hC;
    localparam logic [31:0] EXC_ERET = 32'hE;

    localparam int ST_IE      = 0;
    localparam int ST_EXL     = 1;
    localparam int ST_IM_LO   = 8;
    localparam int ST_IM_HI   = 15;
    localparam int CA_EXC_LO  = 2;
    localparam int CA_EXC_HI  = 6;
    localparam int CA_IPSW_LO = 8;
    localparam int CA_IPSW_HI = 9;
    localparam int CA_IPHW_LO = 10;
    localparam int CA_IPHW_HI = 15;
    localparam int CA_BD      = 31;

    function automatic logic is_addr_exc(input logic [31:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_exc_ctrl_timer.sv
// Count/Compare timer: Count advances every second cycle; the pending
// interrupt latches on a match and is acknowledged by rewriting Compare.
module cp0_timer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_int
);

    logic tick;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tick      <= 1'b0;
            count     <= 32'h0;
            compare   <= 32'h0;
            timer_int <= 1'b0;
        end else begin
            // A software write to Count restarts the half-rate phase.
            if (count_we) begin
                count <= wdata;
                tick  <= 1'b0;
            end else begin
                tick <= ~tick;
                if (tick) count <= count + 32'd1;
            end

            if (compare_we) begin
                compare   <= wdata;
                timer_int <= 1'b0;
            end else if ((compare != 32'h0) && (count == compare)) begin
                timer_int <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 register file with exception commit, eret, MTC0/MFC0 access and the
// flush/redirect path back to the fetch stage.
module cp0_exc_ctrl
    import cp0_exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter logic [31:0] STATUS_RESET = 32'h00400000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] pc_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    input  logic [5:0]  int_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        flush_o,
    output logic [31:0] newpc_o,
    output logic        timer_int_o
);

    logic is_eret;
    logic is_exc;
    logic mtc0;

    assign is_eret = (excepttype_i == EXC_ERET);
    assign is_exc  = (excepttype_i != EXC_NONE) && !is_eret;
    assign flush_o = (excepttype_i != EXC_NONE);
    assign newpc_o = is_eret ? epc_o : EXC_VECTOR;
    // The MTC0 writer sits in the flushed instruction window, so drop it.
    assign mtc0    = we_i && !flush_o;

    cp0_timer u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .count_we   (mtc0 && (waddr_i == CP0_COUNT)),
        .compare_we (mtc0 && (waddr_i == CP0_COMPARE)),
        .wdata      (wdata_i),
        .count      (count_o),
        .compare    (compare_o),
        .timer_int  (timer_int_o)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            status_o   <= STATUS_RESET;
            cause_o    <= 32'h0;
            epc_o      <= 32'h0;
            badvaddr_o <= 32'h0;
        end else begin
            cause_o[CA_IPHW_HI:CA_IPHW_LO] <= {int_i[5] | timer_int_o, int_i[4:0]};

            if (is_exc) begin
                // Nested exceptions keep the original return point.
                if (!status_o[ST_EXL]) begin
                    epc_o          <= is_in_delayslot_i ? (pc_i - 32'd4) : pc_i;
                    cause_o[CA_BD] <= is_in_delayslot_i;
                end
                status_o[ST_EXL] <= 1'b1;
                cause_o[CA_EXC_HI:CA_EXC_LO] <= (excepttype_i == EXC_INT) ? 5'd0 : excepttype_i[4:0];
                if (is_addr_exc(excepttype_i)) badvaddr_o <= bad_addr_i;
            end else if (is_eret) begin
                status_o[ST_EXL] <= 1'b0;
            end else if (mtc0) begin
                case (waddr_i)
                    CP0_STATUS: begin
                        status_o[ST_IM_HI:ST_IM_LO] <= wdata_i[ST_IM_HI:ST_IM_LO];
                        status_o[ST_EXL]            <= wdata_i[ST_EXL];
                        status_o[ST_IE]             <= wdata_i[ST_IE];
                    end
                    CP0_CAUSE: cause_o[CA_IPSW_HI:CA_IPSW_LO] <= wdata_i[CA_IPSW_HI:CA_IPSW_LO];
                    CP0_EPC:   epc_o <= wdata_i;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdata_o = 32'h0;
        case (raddr_i)
            CP0_BADVADDR: rdata_o = badvaddr_o;
            CP0_COUNT:    rdata_o = count_o;
            CP0_COMPARE:  rdata_o = compare_o;
            CP0_STATUS:   rdata_o = status_o;
            CP0_CAUSE:    rdata_o = cause_o;
            CP0_EPC:      rdata_o = epc_o;
            default:      rdata_o = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: a table of commit/MTC0 vectors followed by
// hand-written timer, interrupt-line and mid-operation reset sequences.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] excepttype_i, pc_i, bad_addr_i, wdata_i;
    logic        is_in_delayslot_i, we_i;
    logic [5:0]  int_i;
    logic [4:0]  waddr_i, raddr_i;
    logic [31:0] rdata_o, status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o, newpc_o;
    logic        flush_o, timer_int_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cp0_exc_ctrl dut (
        .clk               (clk),
        .resetn            (resetn),
        .excepttype_i      (excepttype_i),
        .pc_i              (pc_i),
        .is_in_delayslot_i (is_in_delayslot_i),
        .bad_addr_i        (bad_addr_i),
        .int_i             (int_i),
        .we_i              (we_i),
        .waddr_i           (waddr_i),
        .wdata_i           (wdata_i),
        .raddr_i           (raddr_i),
        .rdata_o           (rdata_o),
        .status_o          (status_o),
        .cause_o           (cause_o),
        .epc_o             (epc_o),
        .badvaddr_o        (badvaddr_o),
        .count_o           (count_o),
        .compare_o         (compare_o),
        .flush_o           (flush_o),
        .newpc_o           (newpc_o),
        .timer_int_o       (timer_int_o)
    );

    typedef struct {
        logic [31:0] exc;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] bad;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        flush;
        logic [31:0] newpc;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] badv;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic idle();
        excepttype_i = 32'h0; pc_i = 32'h0; is_in_delayslot_i = 1'b0; bad_addr_i = 32'h0;
        we_i = 1'b0; waddr_i = 5'd0; wdata_i = 32'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        idle();
        we_i = 1'b1; waddr_i = a; wdata_i = d;
        step();
        idle();
    endtask

    localparam logic [31:0] VEC = 32'hBFC00380;

    initial begin
        bit seen;
        //          exc     pc            ds    bad           we    wa     wdata         fl    newpc         status        cause         epc           badv
        tbl[0]  = '{32'h0, 32'h0,        1'b0, 32'h0,        1'b1, 5'd12, 32'hFFFFFF01, 1'b0, VEC,          32'h0040FF01, 32'h00000000, 32'h00000000, 32'h0};
        tbl[1]  = '{32'h0, 32'h0,        1'b0, 32'h0,        1'b1, 5'd13, 32'hFFFFFFFF, 1'b0, VEC,          32'h0040FF01, 32'h00000300, 32'h00000000, 32'h0};
        tbl[2]  = '{32'h0, 32'h0,        1'b0, 32'h0,        1'b1, 5'd14, 32'h11111111, 1'b0, VEC,          32'h0040FF01, 32'h00000300, 32'h11111111, 32'h0};
        tbl[3]  = '{32'h0, 32'h0,        1'b0, 32'h0,        1'b1, 5'd8,  32'hDEADBEEF, 1'b0, VEC,          32'h0040FF01, 32'h00000300, 32'h11111111, 32'h0};
        tbl[4]  = '{32'h8, 32'hBFC00100, 1'b1, 32'h0,        1'b0, 5'd0,  32'h0,        1'b1, VEC,          32'h0040FF03, 32'h80000320, 32'hBFC000FC, 32'h0};
        tbl[5]  = '{32'hE, 32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 32'hBFC000FC, 32'h0040FF01, 32'h80000320, 32'hBFC000FC, 32'h0};
        tbl[6]  = '{32'h4, 32'h80000040, 1'b0, 32'h00001235, 1'b0, 5'd0,  32'h0,        1'b1, VEC,          32'h0040FF03, 32'h00000310, 32'h80000040, 32'h00001235};
        tbl[7]  = '{32'hE, 32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 32'h80000040, 32'h0040FF01, 32'h00000310, 32'h80000040, 32'h00001235};
        tbl[8]  = '{32'h1, 32'h80000000, 1'b0, 32'h0,        1'b0, 5'd0,  32'h0,        1'b1, VEC,          32'h0040FF03, 32'h00000300, 32'h80000000, 32'h00001235};
        tbl[9]  = '{32'hC, 32'h80000010, 1'b1, 32'h0,        1'b0, 5'd0,  32'h0,        1'b1, VEC,          32'h0040FF03, 32'h00000330, 32'h80000000, 32'h00001235};
        tbl[10] = '{32'hE, 32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 32'h80000000, 32'h0040FF01, 32'h00000330, 32'h80000000, 32'h00001235};
        tbl[11] = '{32'h1, 32'h80000020, 1'b0, 32'h0,        1'b1, 5'd14, 32'h12345678, 1'b1, VEC,          32'h0040FF03, 32'h00000300, 32'h80000020, 32'h00001235};
        tbl[12] = '{32'h5, 32'h90000000, 1'b0, 32'h0000ABCD, 1'b0, 5'd0,  32'h0,        1'b1, VEC,          32'h0040FF03, 32'h00000314, 32'h80000020, 32'h0000ABCD};
        tbl[13] = '{32'hE, 32'h0,        1'b0, 32'h0,        1'b1, 5'd12, 32'h0,        1'b1, 32'h80000020, 32'h0040FF01, 32'h00000314, 32'h80000020, 32'h0000ABCD};

        idle();
        int_i = 6'd0; raddr_i = 5'd0; resetn = 1'b0;
        repeat (3) step();
        chk("rst_status", status_o, 32'h00400000);
        chk("rst_cause", cause_o, 32'h0);
        chk("rst_epc", epc_o, 32'h0);
        chk("rst_badvaddr", badvaddr_o, 32'h0);
        chk("rst_count", count_o, 32'h0);
        chk("rst_compare", compare_o, 32'h0);
        chk("rst_timer_int", {31'h0, timer_int_o}, 32'h0);
        chk("rst_flush", {31'h0, flush_o}, 32'h0);
        resetn = 1'b1;
        step();

        for (int i = 0; i < 14; i++) begin
            excepttype_i = tbl[i].exc; pc_i = tbl[i].pc; is_in_delayslot_i = tbl[i].ds;
            bad_addr_i = tbl[i].bad; we_i = tbl[i].we; waddr_i = tbl[i].waddr; wdata_i = tbl[i].wdata;
            #2;
            chk($sformatf("v%0d_flush", i), {31'h0, flush_o}, {31'h0, tbl[i].flush});
            chk($sformatf("v%0d_newpc", i), newpc_o, tbl[i].newpc);
            step();
            idle();
            chk($sformatf("v%0d_status", i), status_o, tbl[i].status);
            chk($sformatf("v%0d_cause", i), cause_o, tbl[i].cause);
            chk($sformatf("v%0d_epc", i), epc_o, tbl[i].epc);
            chk($sformatf("v%0d_badvaddr", i), badvaddr_o, tbl[i].badv);
        end

        raddr_i = 5'd8;  #1 chk("rd_badvaddr", rdata_o, 32'h0000ABCD);
        raddr_i = 5'd12; #1 chk("rd_status", rdata_o, 32'h0040FF01);
        raddr_i = 5'd13; #1 chk("rd_cause", rdata_o, 32'h00000314);
        raddr_i = 5'd14; #1 chk("rd_epc", rdata_o, 32'h80000020);
        raddr_i = 5'd3;  #1 chk("rd_unmapped", rdata_o, 32'h0);

        // Timer: Compare=3, Count=0, wait for the match.
        mtc0(5'd11, 32'd3);
        mtc0(5'd9, 32'd0);
        chk("tmr_count_written", count_o, 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            step();
            seen = timer_int_o;
        end
        chk("tmr_int_rose", {31'h0, seen}, 32'h1);
        chk("tmr_count_at_int", count_o, 32'd3);
        step();
        chk("tmr_cause15", {31'h0, cause_o[15]}, 32'h1);
        mtc0(5'd11, 32'd100);
        chk("tmr_int_cleared", {31'h0, timer_int_o}, 32'h0);
        raddr_i = 5'd11; #1 chk("rd_compare", rdata_o, 32'd100);

        int_i = 6'b000101;
        step();
        step();
        chk("hw_ip", {26'h0, cause_o[15:10]}, 32'h5);
        int_i = 6'd0;

        // Count wraps from all-ones after two cycles.
        mtc0(5'd9, 32'hFFFFFFFF);
        chk("wrap_pre", count_o, 32'hFFFFFFFF);
        step();
        step();
        chk("wrap_post", count_o, 32'h0);

        // Reset mid-operation discards the coincident exception and write.
        excepttype_i = 32'h8; pc_i = 32'h80001000; we_i = 1'b1; waddr_i = 5'd14; wdata_i = 32'hAAAA5555;
        resetn = 1'b0;
        step();
        idle();
        chk("midrst_epc", epc_o, 32'h0);
        chk("midrst_status", status_o, 32'h00400000);
        chk("midrst_cause", cause_o, 32'h0);
        chk("midrst_compare", compare_o, 32'h0);
        chk("midrst_timer_int", {31'h0, timer_int_o}, 32'h0);
        resetn = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Exception-commit controller and CP0 register file for the MIPS pipeline.
- Consumes the 32-bit excepttype code produced by the exception-type encoder at the MEM stage and updates Status, Cause, EPC and BadVAddr.
- Drives pipeline flush and the redirect PC, and runs the Count/Compare timer.
- Also serves MFC0 reads and MTC0 writes; its Status and Cause outputs feed back into the encoder for interrupt masking.

Parameters:
- EXC_VECTOR, 32'hBFC00380, redirect PC for every exception except eret.
- STATUS_RESET, 32'h00400000, Status reset value (BEV=1, IM=0, EXL=0, IE=0).

Ports:
- clk  in  1  pipeline clock
- resetn  in  1  synchronous reset, active-low
- excepttype_i  in  32  committed exception code: 0 none, 1 int, 4 AdEL, 5 AdES, 8 Sys, 9 Bp, A RI, C Ov, E eret
- pc_i  in  32  PC of the excepting MEM-stage instruction
- is_in_delayslot_i  in  1  MEM instruction is in a branch delay slot
- bad_addr_i  in  32  faulting address (fetch PC or data address)
- int_i  in  6  hardware interrupt lines
- we_i  in  1  MTC0 write enable
- waddr_i  in  5  MTC0 register number
- wdata_i  in  32  MTC0 data
- raddr_i  in  5  MFC0 register number
- rdata_o  out  32  MFC0 data, combinational
- status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o  out  32 each  register contents
- flush_o  out  1  flush IF..MEM, combinational
- newpc_o  out  32  redirect PC, valid when flush_o=1
- timer_int_o  out  1  Count==Compare pending

Behaviour:
- Reset (resetn=0 at a clk edge):
  - Status=STATUS_RESET.
  - Cause, EPC, BadVAddr, Count, Compare=0; tick=0; timer_int_o=0.
  - A mid-operation reset discards any pending write or exception in the same cycle.
- Register map (numbers): 8 BadVAddr (read-only), 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC. Any other number reads 0; writes to it are ignored.
- Writable bits:
  - Status: IM[15:8], EXL[1], IE[0]; all other bits hold their reset value.
  - Cause: IP[9:8] only.
- Cause.IP[15:10] is updated every cycle from int_i[5:0]. Bit 15 = int_i[5] OR timer_int_o.
- Timer:
  - tick toggles every cycle; Count increments by 1 when tick=1, i.e. every 2 cycles, wrapping at 2^32.
  - timer_int_o sets on the edge where Count==Compare and Compare!=0.
  - timer_int_o clears only on an MTC0 write to Compare.
  - An MTC0 write to Count takes priority over the increment in the same cycle and resets tick to 0.
- flush_o = (excepttype_i != 0). newpc_o = EPC if excepttype_i==E, else EXC_VECTOR. Zero-latency redirect.
- Exception commit, excepttype_i not in {0, E}, takes effect at the next edge:
  - If Status.EXL==0: EPC <= is_in_delayslot_i ? pc_i-4 : pc_i, and Cause.BD[31] <= is_in_delayslot_i.
  - If Status.EXL==1: EPC and BD are unchanged (nested exception).
  - Status.EXL <= 1.
  - Cause.ExcCode[6:2] <= 0 if code==1, otherwise excepttype_i[4:0].
  - For codes 4 and 5: BadVAddr <= bad_addr_i.
- eret (E): Status.EXL <= 0 at the next edge; no other register changes.
- Priority: an exception or eret in a cycle suppresses that cycle's MTC0 write, since the writer is flushed. Hardware IP and timer updates still occur.
- MFC0 read-after-write in the same cycle returns the old value; forwarding is done in the pipeline.

Decomposition:
- Shared package holds:
  - CP0 register numbers (CP0_BADVADDR=8 ... CP0_EPC=14).
  - excepttype codes (EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV, EXC_ERET).
  - Status/Cause bit positions (EXL, IE, IM, IP, BD, EXCCODE).
- One sub-module, cp0_timer: holds tick, Count, Compare and timer_int, with its own write-enable inputs for Count and Compare.

Test Plan:
- Reset: hold resetn=0 for 3 cycles -> status_o=00400000; cause, epc, badvaddr, count, compare, timer_int_o all 0; flush_o=0.
- Timer: MTC0 Compare=3, then MTC0 Count=0 -> timer_int_o rises on the edge where count_o reaches 3 (about 6 cycles later) and cause_o[15]=1. Next MTC0 Compare -> timer_int_o=0.
- Syscall in delay slot: excepttype=8, pc=BFC00100, delayslot=1 -> same cycle flush_o=1, newpc_o=BFC00380. Next cycle epc_o=BFC000FC, cause_o[31]=1, ExcCode=8, status_o[1]=1.
- AdEL: excepttype=4, bad_addr=00001235 -> badvaddr_o=00001235, ExcCode=4. Follow with excepttype=E -> newpc_o=EPC, then status_o[1]=0.
- Nested: with EXL=1, excepttype=C at pc=80000010 -> epc_o unchanged, ExcCode=12.
- Conflict: MTC0 EPC=12345678 in the same cycle as excepttype=1, pc=80000020 -> epc_o=80000020, ExcCode=0; the MTC0 write is dropped.
